// File: rtl/iq_unzip_expand.sv
// iq_unzip_expand: expands 32-bit words of four packed 4-bit IQ symbols into four 16/16-bit IQ samples.
// Latency: sample 0 is registered one cycle after the input word is accepted; one sample per cycle after that.
// Backpressure: o_tready low holds the sample; a new word is taken only while empty or in the lane-3 handoff.
// Optional build macro IQ_UNZIP_ROUND_EN: also sets bit 8 of every expanded half (mid-rise reconstruction).
module iq_unzip_expand #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  typedef enum logic {
    EMPTY  = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   word_buf;
  logic               last_q;
  logic [CNT_W-1:0]   lane;
  logic               full;
  logic               lane_end;
  logic               in_acc;
  logic               out_acc;

  // One nibble to 16 bits: sign bit, three copies of it, the three magnitude bits, then zeros.
  function automatic logic [15:0] expand_nib(input logic [3:0] n);
    logic [15:0] h;
    h = {n[3], {3{n[3]}}, n[2:0], 9'd0};
`ifdef IQ_UNZIP_ROUND_EN
    h[8] = 1'b1;
`endif
    return h;
  endfunction

  // Symbol byte to one output sample {I, Q}.
  function automatic logic [31:0] expand_sym(input logic [7:0] b);
    return {expand_nib(b[7:4]), expand_nib(b[3:0])};
  endfunction

  // Fixed lane order inside a word: [23:16], [31:24], [7:0], [15:8].
  function automatic logic [7:0] lane_byte(input logic [WIDTH-1:0] w, input logic [CNT_W-1:0] l);
    logic [7:0] b;
    case (l)
      2'd0:    b = w[23:16];
      2'd1:    b = w[31:24];
      2'd2:    b = w[7:0];
      default: b = w[15:8];
    endcase
    return b;
  endfunction

  assign full     = (state == EXPAND);
  assign lane_end = (lane == '1);
  assign in_acc   = i_tvalid & i_tready;
  assign out_acc  = full & o_tready;

  // State register; reset drops any word in flight at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: fill on accept, empty only when lane 3 leaves with no word waiting.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (in_acc) begin
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        if (out_acc && lane_end && !i_tvalid) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs; refill is allowed in the same cycle lane 3 is consumed.
  always_comb begin
    o_tvalid = full;
    i_tready = ~full | (lane_end & o_tready);
    o_tlast  = full & last_q & lane_end;
  end

  // Word buffer, lane counter and registered sample; all hold while the output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_buf <= '0;
      last_q   <= 1'b0;
      lane     <= '0;
      o_tdata  <= '0;
    end else if (in_acc) begin
      // Covers both the load from empty and the lane-3 pass-through refill.
      word_buf <= i_tdata;
      last_q   <= i_tlast;
      lane     <= '0;
      o_tdata  <= expand_sym(lane_byte(i_tdata, '0));
    end else if (out_acc) begin
      if (!lane_end) begin
        lane    <= lane + CNT_W'(1);
        o_tdata <= expand_sym(lane_byte(word_buf, lane + CNT_W'(1)));
      end else begin
        lane    <= '0;
      end
    end
  end

endmodule
